// File: rtl/opb_register_bank_ppc2simulink_pkg.sv
// Shared OPB slave helpers: FSM states, latched request, byte-lane mapping
// and the ack/zero read-bus rule.
package opb_reg_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_HOLD = 2'd2
  } opb_state_e;

  localparam int REG_STRIDE = 4;

  // Request captured when a transfer is accepted. be[3] is OPB_BE[0]
  // (bits 31:24) so that be[j] always selects bits 8j+7:8j.
  typedef struct packed {
    logic [31:0] off;
    logic        rnw;
    logic [3:0]  be;
    logic [31:0] data;
  } opb_req_t;

  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // OPB slaves must drive zero on the shared data bus unless acking a read
  function automatic logic [31:0] ack_bus(input logic ack, input logic [31:0] d);
    return ack ? d : 32'h0;
  endfunction

endpackage

// File: rtl/opb_register_bank_ppc2simulink_if.sv
// OPB slave-side bus signals, kept in OPB big-endian bit numbering.
interface opb_register_bank_ppc2simulink_if;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );
endinterface

// File: rtl/opb_register_bank_ppc2simulink_fsm.sv
// OPB slave transfer FSM: window decode, single-cycle ack, and a HOLD state
// so one select assertion yields exactly one ack.
module opb_slave_fsm
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR = 32'h0000_00FF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        select,
  input  logic [31:0] addr,
  input  logic        rnw,
  input  logic [3:0]  be,
  input  logic [31:0] data,
  output logic        ack,
  output opb_req_t    req
);

  opb_state_e  state;
  logic        ack_q;
  logic [31:0] off;
  logic        hit;

  // below-base addresses wrap to large offsets and miss the window
  assign off = addr - C_BASEADDR;
  assign hit = (off <= (C_HIGHADDR - C_BASEADDR));

  // accept in IDLE, ack for one cycle, then wait for select to drop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ack_q <= 1'b0;
      req   <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state)
        S_IDLE: if (select && hit) begin
          state <= S_ACK;
          ack_q <= 1'b1;
          req   <= '{off: off, rnw: rnw, be: be, data: data};
        end
        S_ACK:  state <= S_HOLD;
        S_HOLD: if (!select) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // a reset landing on the ack cycle suppresses that ack
  assign ack = ack_q & rst_n;

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// Bank of C_NUM_REGS software-writable 32-bit registers on OPB with
// byte-enable writes, update strobes, self-clearing pulse bits in register 0
// and an optional shadow/commit mode so a set of registers changes together.
module opb_register_bank_ppc2simulink
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_NUM_REGS   = 4,
  parameter int          C_ATOMIC     = 0,
  parameter logic [31:0] C_PULSE_MASK = 32'h0000_0000,
  parameter string       C_FAMILY     = "virtex5"
) (
  input  logic                           OPB_Clk,
  input  logic                           OPB_Rst_n,
  opb_register_bank_ppc2simulink_if.slave opb,
  output logic [32*C_NUM_REGS-1:0]       user_data_out,
  output logic [C_NUM_REGS-1:0]          user_update
);

  if (C_OPB_DWIDTH != 32 || C_OPB_AWIDTH != 32 || C_NUM_REGS < 1 || C_NUM_REGS > 32)
    $error("opb_register_bank_ppc2simulink: unsupported bus width or register count");
  if ((C_HIGHADDR - C_BASEADDR + 32'd1) < 32'(REG_STRIDE * (C_NUM_REGS + 1)))
    $error("opb_register_bank_ppc2simulink: address window too small");

  logic     ack;
  opb_req_t req;

  opb_slave_fsm #(
    .C_BASEADDR (C_BASEADDR),
    .C_HIGHADDR (C_HIGHADDR)
  ) u_fsm (
    .clk    (OPB_Clk),
    .rst_n  (OPB_Rst_n),
    .select (opb.OPB_select),
    .addr   (opb.OPB_ABus),
    .rnw    (opb.OPB_RNW),
    .be     (opb.OPB_BE),
    .data   (opb.OPB_DBus),
    .ack    (ack),
    .req    (req)
  );

  logic [C_NUM_REGS-1:0][31:0] out_q, shd_q;
  logic [C_NUM_REGS-1:0]       upd_q;
  logic [31:0]                 word, wmask, rd_data;
  logic                        wr, commit;

  assign word   = req.off / 32'(REG_STRIDE);
  assign wmask  = be_to_mask(req.be);
  assign wr     = ack & ~req.rnw;
  assign commit = (word == 32'(C_NUM_REGS));

  // register/shadow update, commit copy and pulse-bit self-clear
  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      out_q <= '0;
      shd_q <= '0;
      upd_q <= '0;
    end else begin
      upd_q    <= '0;
      out_q[0] <= out_q[0] & ~C_PULSE_MASK;
      if (wr && C_ATOMIC != 0 && commit) begin
        // commit overrides the self-clear so committed pulse bits show once
        out_q    <= shd_q;
        shd_q[0] <= shd_q[0] & ~C_PULSE_MASK;
        upd_q    <= '1;
      end
      for (int i = 0; i < C_NUM_REGS; i++) begin
        if (wr && word == 32'(i)) begin
          if (C_ATOMIC != 0) begin
            shd_q[i] <= (shd_q[i] & ~wmask) | (req.data & wmask);
          end else begin
            out_q[i] <= (out_q[i] & ~wmask) | (req.data & wmask);
            upd_q[i] <= 1'b1;
          end
        end
      end
    end
  end

  // read-back of output registers; pulse bits never read back as 1
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < C_NUM_REGS; i++)
      if (word == 32'(i)) rd_data = (i == 0) ? (out_q[i] & ~C_PULSE_MASK) : out_q[i];
  end

  assign opb.Sl_DBus    = ack_bus(ack & req.rnw, rd_data);
  assign opb.Sl_xferAck = ack;
  assign opb.Sl_errAck  = 1'b0;
  assign opb.Sl_retry   = 1'b0;
  assign opb.Sl_toutSup = 1'b0;

  assign user_data_out = out_q;
  assign user_update   = upd_q;

  // burst hint is irrelevant: every beat is a single transfer
  logic unused_seq;
  assign unused_seq = opb.OPB_seqAddr;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Bench: a direct-mode and an atomic-mode instance share identical bus
// stimulus; a per-cycle register-level model predicts every output.
module tb_opb_register_bank_ppc2simulink;
  localparam int          N    = 4;
  localparam logic [31:0] HIGH = 32'h0000_00FF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  opb_register_bank_ppc2simulink_if bus0 ();
  opb_register_bank_ppc2simulink_if bus1 ();
  logic [32*N-1:0] udo0, udo1;
  logic [N-1:0]    upd0, upd1;

  opb_register_bank_ppc2simulink #(
    .C_BASEADDR(32'h0), .C_HIGHADDR(HIGH), .C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32),
    .C_NUM_REGS(N), .C_ATOMIC(0), .C_PULSE_MASK(32'h0000_0001), .C_FAMILY("virtex5")
  ) dut0 (.OPB_Clk(clk), .OPB_Rst_n(rst_n), .opb(bus0), .user_data_out(udo0), .user_update(upd0));

  opb_register_bank_ppc2simulink #(
    .C_BASEADDR(32'h0), .C_HIGHADDR(HIGH), .C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32),
    .C_NUM_REGS(N), .C_ATOMIC(1), .C_PULSE_MASK(32'h8000_0000), .C_FAMILY("virtex5")
  ) dut1 (.OPB_Clk(clk), .OPB_Rst_n(rst_n), .opb(bus1), .user_data_out(udo1), .user_update(upd1));

  // model state: expected outputs/shadows per instance (0 = direct, 1 = atomic)
  logic [31:0]  m_out [2][N];
  logic [31:0]  m_shd [2][N];
  logic [N-1:0] m_upd [2];
  logic [31:0]  m_dbus [2];
  logic         m_ack;

  int errors = 0, checks = 0;
  bit chk_en = 1'b0;
  int ack_cnt = 0, n_upd0100 = 0, n_commit = 0, n_p0 = 0, n_p1 = 0;
  logic [31:0] last_rd0 = '0, last_rd1 = '0;

  function automatic logic [31:0] pm(input int d);
    return (d == 0) ? 32'h0000_0001 : 32'h8000_0000;
  endfunction

  function automatic logic [31:0] lanes(input logic [3:0] be);
    logic [31:0] m = '0;
    for (int j = 0; j < 4; j++) if (be[j]) m[8*j +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic logic [127:0] flat(input int d);
    logic [127:0] f = '0;
    for (int i = 0; i < N; i++) f[32*i +: 32] = m_out[d][i];
    return f;
  endfunction

  function automatic logic [31:0] m_read(input int d, input logic [31:0] a);
    int w = int'(a / 32'd4);
    if (w >= N) return 32'h0;
    if (w == 0) return m_out[d][0] & ~pm(d);
    return m_out[d][w];
  endfunction

  task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // effect of an accepted write as seen in the cycle after the ack
  task automatic m_write(input logic [31:0] a, input logic [31:0] dat, input logic [3:0] be);
    int w = int'(a / 32'd4);
    logic [31:0] m = lanes(be);
    for (int d = 0; d < 2; d++) begin
      if (w < N) begin
        if (d == 1) m_shd[d][w] = (m_shd[d][w] & ~m) | (dat & m);
        else begin
          m_out[d][w] = (m_out[d][w] & ~m) | (dat & m);
          m_upd[d][w] = 1'b1;
        end
      end else if (w == N && d == 1) begin
        for (int i = 0; i < N; i++) m_out[d][i] = m_shd[d][i];
        m_shd[d][0] = m_shd[d][0] & ~pm(d);
        m_upd[d] = '1;
      end
    end
  endtask

  // advance one clock; strobes drop, pulse bits drop, reset clears all
  task automatic tick();
    bit r;
    @(posedge clk);
    r = rst_n;
    #1;
    for (int d = 0; d < 2; d++) begin
      m_upd[d] = '0;
      if (!r) for (int i = 0; i < N; i++) begin m_out[d][i] = '0; m_shd[d][i] = '0; end
      else m_out[d][0] = m_out[d][0] & ~pm(d);
    end
  endtask

  task automatic drive(input bit sel, input logic [31:0] a, input bit rnw,
                       input logic [31:0] dat, input logic [3:0] be);
    bus0.OPB_select = sel; bus0.OPB_ABus = a; bus0.OPB_RNW = rnw;
    bus0.OPB_DBus = dat;   bus0.OPB_BE = be;  bus0.OPB_seqAddr = 1'b0;
    bus1.OPB_select = sel; bus1.OPB_ABus = a; bus1.OPB_RNW = rnw;
    bus1.OPB_DBus = dat;   bus1.OPB_BE = be;  bus1.OPB_seqAddr = 1'b0;
  endtask

  // one transfer with select held for 'hold' cycles; returns in an idle cycle
  task automatic beat(input logic [31:0] a, input bit rnw, input logic [31:0] dat,
                      input logic [3:0] be, input int hold);
    bit hit = (a <= HIGH);
    int c = 0;
    drive(1'b1, a, rnw, dat, be);
    m_ack = 1'b0; m_dbus[0] = '0; m_dbus[1] = '0;
    while (1) begin
      tick();
      c++;
      m_ack = (c == 1) && hit;
      for (int d = 0; d < 2; d++) m_dbus[d] = (c == 1 && hit && rnw) ? m_read(d, a) : 32'h0;
      if (c == 2 && hit && !rnw) m_write(a, dat, be);
      if (c >= hold) drive(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
      if (c > hold && c >= 3) break;
    end
  endtask

  // compare every output of both instances against the model each cycle
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("ack0", bus0.Sl_xferAck, m_ack);
      cmp("ack1", bus1.Sl_xferAck, m_ack);
      cmp("dbus0", bus0.Sl_DBus, m_dbus[0]);
      cmp("dbus1", bus1.Sl_DBus, m_dbus[1]);
      cmp("udo0", udo0, flat(0));
      cmp("udo1", udo1, flat(1));
      cmp("upd0", upd0, m_upd[0]);
      cmp("upd1", upd1, m_upd[1]);
      if (bus0.Sl_xferAck) ack_cnt++;
      if (bus0.Sl_xferAck && bus0.OPB_RNW) last_rd0 = bus0.Sl_DBus;
      if (bus1.Sl_xferAck && bus1.OPB_RNW) last_rd1 = bus1.Sl_DBus;
      if (upd0 == 4'b0100) n_upd0100++;
      if (upd1 == 4'b1111) n_commit++;
      if (udo0[0]) n_p0++;
      if (udo1[31]) n_p1++;
    end
  end

  initial begin
    int a0, u0, p0;
    drive(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
    m_ack = 1'b0; m_dbus[0] = '0; m_dbus[1] = '0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk_en = 1'b1;
    cmp("rst_udo0", udo0, 128'h0);
    cmp("rst_udo1", udo1, 128'h0);

    // reads after reset: all zero, one ack each
    a0 = ack_cnt;
    for (int i = 0; i < N; i++) beat(32'(4 * i), 1'b1, 32'h0, 4'h0, 1);
    cmp("rst_read_acks", 32'(ack_cnt - a0), 32'd4);
    cmp("rst_read_data", last_rd0, 32'h0);

    // direct byte-enable write
    u0 = n_upd0100;
    beat(32'h8, 1'b0, 32'hDEADBEEF, 4'b0101, 1);
    cmp("be_write_reg2", udo0[95:64], 32'h00AD00EF);
    cmp("be_write_strobe", 32'(n_upd0100 - u0), 32'd1);
    beat(32'h8, 1'b1, 32'h0, 4'h0, 1);
    cmp("be_readback", last_rd0, 32'h00AD00EF);

    // atomic: shadows invisible until commit, then all together
    beat(32'h0, 1'b0, 32'h11111111, 4'hF, 1);
    beat(32'h4, 1'b0, 32'h22222222, 4'hF, 1);
    cmp("shadow_hidden", udo1, 128'h0);
    u0 = n_commit;
    beat(32'h10, 1'b0, 32'hFFFFFFFF, 4'hF, 1);
    cmp("commit_outputs", udo1[63:0], 64'h22222222_11111111);
    cmp("commit_strobe", 32'(n_commit - u0), 32'd1);

    // pulse bit in direct mode
    p0 = n_p0;
    beat(32'h0, 1'b0, 32'h00000005, 4'hF, 1);
    cmp("pulse_once", 32'(n_p0 - p0), 32'd1);
    cmp("pulse_cleared", udo0[31:0], 32'h00000004);
    beat(32'h0, 1'b1, 32'h0, 4'h0, 1);
    cmp("pulse_readback", last_rd0, 32'h00000004);

    // pulse bit in atomic mode fires on commit only
    p0 = n_p1;
    beat(32'h0, 1'b0, 32'h80000003, 4'hF, 1);
    beat(32'h10, 1'b0, 32'h0, 4'hF, 1);
    beat(32'h10, 1'b0, 32'h0, 4'hF, 1);
    cmp("atomic_pulse_once", 32'(n_p1 - p0), 32'd1);
    cmp("atomic_pulse_after", udo1[31:0], 32'h00000003);

    // long select gives a single ack
    a0 = ack_cnt;
    beat(32'h4, 1'b1, 32'h0, 4'h0, 6);
    cmp("long_select_acks", 32'(ack_cnt - a0), 32'd1);

    // outside the window: never acked; inside but unmapped: acked, reads 0
    a0 = ack_cnt;
    beat(HIGH + 32'd4, 1'b1, 32'h0, 4'h0, 1);
    beat(HIGH + 32'd4, 1'b0, 32'hFFFFFFFF, 4'hF, 1);
    cmp("oow_acks", 32'(ack_cnt - a0), 32'd0);
    beat(32'h40, 1'b1, 32'h0, 4'h0, 1);
    beat(32'h40, 1'b0, 32'hFFFFFFFF, 4'hF, 1);
    cmp("unmapped_acks", 32'(ack_cnt - a0), 32'd2);
    cmp("unmapped_read", last_rd0, 32'h0);

    // reset landing on the ack cycle of a write
    a0 = ack_cnt;
    drive(1'b1, 32'hC, 1'b0, 32'hFFFFFFFF, 4'hF);
    m_ack = 1'b0;
    tick();
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
    tick();
    rst_n = 1'b1;
    tick();
    cmp("rst_mid_acks", 32'(ack_cnt - a0), 32'd0);
    cmp("rst_mid_reg3", udo0[127:96], 32'h0);
    beat(32'hC, 1'b0, 32'h12345678, 4'hF, 1);
    beat(32'hC, 1'b1, 32'h0, 4'h0, 1);
    cmp("post_rst_readback", last_rd0, 32'h12345678);
    cmp("post_rst_atomic_read", last_rd1, 32'h0);

    tick();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/opb_register_bank_ppc2simulink.md
# opb_register_bank_ppc2simulink

Parametrised OPB slave exposing `C_NUM_REGS` software-writable 32-bit control registers to fabric logic, with byte-enable writes, read-back, per-register update strobes, self-clearing pulse bits and an optional atomic commit mode. It is the multi-register successor to the single ppc2simulink register. It sits on the PPC OPB bus beside the other register cores and replaces banks of single-register instances (e.g. quantiser address/coefficient sets) that must change together.

## Interface
- `C_BASEADDR`, 32'h0000_0000, base of register window
- `C_HIGHADDR`, 32'h0000_00FF, top of window; must cover `4*(C_NUM_REGS+1)` bytes
- `C_OPB_AWIDTH`, 32, OPB address width
- `C_OPB_DWIDTH`, 32, OPB data width (only 32 supported)
- `C_NUM_REGS`, 4, register count, 1..32
- `C_ATOMIC`, 0, 1 = writes land in shadows; outputs change only on commit
- `C_PULSE_MASK`, 32'h0000_0000, bits of register 0 that self-clear one cycle after being written 1
- `C_FAMILY`, "virtex5", target family
- One clock; reset is synchronous and active-low.
- `OPB_Clk` in 1: sole clock, bus and user side.
- `OPB_Rst_n` in 1: synchronous active-low reset.
- `OPB_ABus` in [0:31]: address.
- `OPB_BE` in [0:3]: byte enables; BE[0] = DBus[0:7] = register bits 31:24.
- `OPB_DBus` in [0:31]: write data.
- `OPB_RNW` in 1: 1 = read.
- `OPB_select` in 1: transfer request.
- `OPB_seqAddr` in 1: ignored; each beat is handled as a single transfer.
- `Sl_DBus` out [0:31]: read data; zero when not acking.
- `Sl_xferAck` out 1: transfer acknowledge.
- `Sl_errAck`, `Sl_retry`, `Sl_toutSup` out 1: tied 0.
- `user_data_out` out [32*C_NUM_REGS-1:0]: register i on bits `32*i+31 : 32*i`.
- `user_update` out [C_NUM_REGS-1:0]: one-cycle strobe when register i output is written or committed.

## Operation
- Address map: register i at `C_BASEADDR + 4*i`. Commit register at `C_BASEADDR + 4*C_NUM_REGS` (write-only, data ignored, reads 0). Other in-window offsets are acked; reads return 0 and writes are dropped. Out-of-window addresses are never acked.
- FSM states:
  - IDLE: `OPB_select` with an in-window address goes to ACK.
  - ACK: `Sl_xferAck`=1 for exactly one cycle; then HOLD.
  - HOLD: returns to IDLE on the first cycle `OPB_select`=0. This guarantees one ack per select assertion.
- Write in ACK: for each byte with BE set, update the target (shadow if `C_ATOMIC`, else output register). Bytes with BE clear are unchanged.
- `C_ATOMIC`=0: `user_update[i]` pulses the cycle after a write to register i.
- `C_ATOMIC`=1: a commit write copies all shadows to outputs in one cycle and pulses all `user_update` bits together the following cycle. Shadow writes alone do not pulse.
- Read in ACK: `Sl_DBus` = output register (not shadow), with `C_PULSE_MASK` bits forced 0 for register 0.
- Pulse bits: a bit in `C_PULSE_MASK` written 1 drives `user_data_out` high for exactly one cycle, then clears. This applies in both modes: in atomic mode the pulse occurs on commit, and the shadow pulse bits clear after commit.

## Timing
- Reset: all outputs 0, all shadows 0, FSM in IDLE, `user_update` 0.
- Reset asserted mid-transfer: FSM goes to IDLE, no ack is issued, and a pending write is discarded.
- Select sampled in cycle T: ack in cycle T+1. Register output updates at T+2; `user_update` is high during T+2.
- Commit and shadow timing are identical to direct writes.
- Minimum beat spacing is 3 cycles (IDLE, ACK, HOLD with select low).

## Structure
- Shared package `opb_reg_pkg`: FSM state enum, address-offset constant `REG_STRIDE=4`, a byte-lane mapping function, and the ack/zero-bus rule, for reuse by future OPB slaves.
- One natural sub-module: `opb_slave_fsm` (decode, ack, HOLD). The register array and commit logic live in the top level.

## Test plan
- Reset, then read registers 0..3 → all `Sl_DBus` 0; `user_data_out` 0; exactly one ack per read at T+1.
- `C_ATOMIC`=0: write 32'hDEADBEEF to reg 2 with BE=4'b0101 → reg 2 = 32'h00AD00EF; `user_update`=4'b0100 for one cycle; read-back matches.
- `C_ATOMIC`=1: write 32'h11111111 to reg 0 and 32'h22222222 to reg 1 → outputs stay 0. Write commit → both appear in the same cycle and `user_update`=4'b1111 for one cycle.
- `C_PULSE_MASK`=32'h1: write 32'h00000005 to reg 0 → bit 0 high one cycle then 0; bit 2 stays 1; read-back returns 32'h00000004.
- Hold `OPB_select` high for 6 cycles → exactly one `Sl_xferAck`. Access at `C_HIGHADDR+4` → no ack and `Sl_DBus` 0.
- Assert `OPB_Rst_n`=0 in the ACK cycle of a write → no ack, target register unchanged (0), FSM accepts the next transfer normally.
